store_buffer: RTL and testbench
===============================

# store_buffer

Store-side counterpart of the writeback load-extraction path. It accepts store requests from the memory stage and aligns each one into a 64-bit data-memory row with a per-byte write strobe. Aligned stores are queued in a small in-order FIFO and drained to data memory over a req/gnt handshake. It also flags loads whose row matches a pending store, so the pipeline can stall them.

## Interface
Parameters:
- DEPTH, 4, number of store entries; power of two, ≥ 2.

Ports:
- clk_i  in  1  clock. One clock domain; all state on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- st_valid_i  in  1  store request valid.
- st_ready_o  out  1  buffer can accept a store.
- st_addr_i  in  64  byte address of the store.
- st_data_i  in  64  store data, right-justified.
- st_byte_en_i  in  2  size, using cpu_consts encodings BYTE / HALF_WORD / WORD / DOUBLE_WORD.
- st_misaligned_o  out  1  one-cycle pulse: the accepted store was misaligned and was dropped.
- mem_req_o  out  1  write request to data memory.
- mem_gnt_i  in  1  data memory accepts the write this cycle.
- mem_addr_o  out  64  row address; bits [2:0] are always 0.
- mem_wr_data_o  out  64  row-aligned write data.
- mem_wr_strb_o  out  8  byte write strobes.
- ld_addr_i  in  64  address of the load currently in the memory stage.
- ld_hazard_o  out  1  a valid entry has the same row as ld_addr_i.
- count_o  out  $clog2(DEPTH)+1  number of valid entries.
- empty_o  out  1  count_o == 0.

## Operation
- **Handshake:** a store is accepted on a cycle where st_valid_i && st_ready_o.
  - st_ready_o = (count < DEPTH), taken from registered count only.
  - A pop in the same cycle does not raise ready.
- **Alignment:** let idx = st_addr_i[2:0].
  - Data = st_data_i << (8*idx), with bits outside the strobed bytes zeroed.
  - Strobe is 8'h01<<idx for BYTE, 8'h03<<idx for HALF_WORD, 8'h0F<<idx for WORD, 8'hFF for DOUBLE_WORD.
- **Misalignment:** a store is misaligned if it is HALF_WORD with idx[0]=1, WORD with idx[1:0]≠0, or DOUBLE_WORD with idx≠0.
  - A misaligned store is still accepted, so the handshake completes.
  - It is not enqueued, and st_misaligned_o pulses the cycle after acceptance.
- **Entry contents:** row address {addr[63:3],3'b0}, aligned data, strobe. Entries are written at the tail and drained from the head, strictly in order.
- **Drain FSM:**
  - IDLE → BUSY when count>0: head entry loaded into the mem output registers, mem_req_o=1.
  - BUSY, no mem_gnt_i: outputs held stable.
  - BUSY, mem_gnt_i: head popped. If another entry remains, the next head is loaded that same edge and the FSM stays BUSY (back-to-back). Otherwise it returns to IDLE with mem_req_o=0.
- **Entry lifetime:** the in-flight entry stays counted and hazard-visible until it is granted.
- **Load hazard:** ld_hazard_o = OR over valid entries of (entry row == ld_addr_i[63:3]). It is combinational and includes the in-flight entry.
- **Simultaneous push and pop:** count is unchanged; pointers wrap modulo DEPTH.
- **Reset, asynchronous, at any time:**
  - All entries are discarded and pointers/count go to 0; FSM goes to IDLE.
  - mem_req_o drops immediately; the memory must tolerate an abandoned request.

## Timing
- Reset values:
  - st_ready_o=1, empty_o=1, count_o=0.
  - st_misaligned_o=0, mem_req_o=0.
  - mem_addr_o, mem_wr_data_o and mem_wr_strb_o = 0.
  - ld_hazard_o=0.
- Store accepted at cycle N into an empty buffer: count_o=1 at N+1, mem_req_o=1 at N+2.
- Grant at cycle M with more entries: next request is presented at M+1 (one write per cycle sustained).
- mem_req_o and the mem_* outputs are registered.
- ld_hazard_o is the only combinational output; there is no path from mem_gnt_i or st_valid_i to st_ready_o.

## Structure
- cpu_consts holds the existing BYTE / HALF_WORD / WORD / DOUBLE_WORD encodings. Add to it:
  - sb_entry_t, a packed struct {row_addr[63:3], data[63:0], strb[7:0]};
  - the sb_state_t enum {SB_IDLE, SB_BUSY}.
- Sub-module store_align: combinational; takes addr[2:0], data and size; produces aligned data, strobe and misaligned.
- store_buffer holds the FIFO storage, pointers, count, drain FSM and hazard compare.

## Test plan
- Byte store (BYTE) at 0x1003, data 0xAB → mem_addr_o 0x1000, mem_wr_data_o 0x0000_0000_AB00_0000, strb 0x08, mem_req_o rises 2 cycles after acceptance.
- WORD store at 0x2004, data 0x1234_5678 → data 0x1234_5678_0000_0000, strb 0xF0. DOUBLE_WORD store at 0x2000, data 0xFBD2_67A6_10FF_4483 → same data, strb 0xFF.
- HALF_WORD store at 0x3001 → st_misaligned_o pulse for one cycle, count_o stays 0, mem_req_o stays 0.
- DEPTH=4, mem_gnt_i held 0, five stores offered → four accepted, st_ready_o=0. One grant → ready=1 next cycle, fifth accepted. All five drained in issue order with gnt tied 1, one per cycle.
- One entry at row 0x1000 → ld_addr_i 0x1007 gives ld_hazard_o=1; 0x1008 gives 0. After the grant, 0x1007 gives 0.
- reset_i asserted while BUSY with 3 entries → mem_req_o, count_o, ld_hazard_o go to 0 and empty_o to 1 without a clock edge; after release, a new store drains normally.

Source files
------------

// File: rtl/cpu_consts.sv
// Shared CPU constants: access-size encodings plus the store-buffer entry and
// drain-state types.
package cpu_consts;

    localparam logic [1:0] BYTE        = 2'b00;
    localparam logic [1:0] HALF_WORD   = 2'b01;
    localparam logic [1:0] WORD        = 2'b10;
    localparam logic [1:0] DOUBLE_WORD = 2'b11;

    typedef struct packed {
        logic [63:3] row_addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } sb_entry_t;

    typedef enum logic {SB_IDLE, SB_BUSY} sb_state_t;

endpackage

// File: rtl/store_align.sv
// Combinational store alignment: places right-justified store data into its
// 64-bit row lane, builds the byte strobe and flags misaligned accesses.
module store_align
    import cpu_consts::*;
(
    input  logic [2:0]  i_addr_lo,
    input  logic [63:0] i_data,
    input  logic [1:0]  i_size,
    output logic [63:0] o_data,
    output logic [7:0]  o_strb,
    output logic        o_misaligned
);

    logic [7:0]  w_base_strb;
    logic [63:0] w_shifted;

    always_comb begin
        w_base_strb  = 8'h01;
        o_misaligned = 1'b0;
        case (i_size)
            BYTE:        w_base_strb = 8'h01;
            HALF_WORD: begin
                w_base_strb  = 8'h03;
                o_misaligned = i_addr_lo[0];
            end
            WORD: begin
                w_base_strb  = 8'h0F;
                o_misaligned = |i_addr_lo[1:0];
            end
            DOUBLE_WORD: begin
                w_base_strb  = 8'hFF;
                o_misaligned = |i_addr_lo;
            end
        endcase
        o_strb    = (i_size == DOUBLE_WORD) ? 8'hFF : (w_base_strb << i_addr_lo);
        w_shifted = i_data << {i_addr_lo, 3'b000};
        o_data    = '0;
        // Bytes outside the strobe are forced to zero so memory never sees stale upper data.
        for (int b = 0; b < 8; b++) begin
            o_data[8*b +: 8] = w_shifted[8*b +: 8] & {8{o_strb[b]}};
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: aligns stores into row writes, queues them and drains
// them to data memory over req/gnt, flagging loads that hit a pending row.
module store_buffer
    import cpu_consts::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     st_valid_i,
    output logic                     st_ready_o,
    input  logic [63:0]              st_addr_i,
    input  logic [63:0]              st_data_i,
    input  logic [1:0]               st_byte_en_i,
    output logic                     st_misaligned_o,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic [63:0]              mem_addr_o,
    output logic [63:0]              mem_wr_data_o,
    output logic [7:0]               mem_wr_strb_o,
    input  logic [63:0]              ld_addr_i,
    output logic                     ld_hazard_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    sb_state_t     r_state;
    logic          r_mis;
    logic [63:0]   r_mem_addr;
    logic [63:0]   r_mem_data;
    logic [7:0]    r_mem_strb;

    sb_state_t     w_next_state;
    logic [63:0]   w_al_data;
    logic [7:0]    w_al_strb;
    logic          w_al_mis;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic [PW-1:0] w_load_idx;
    logic [PW-1:0] w_off;
    logic          w_hazard;
    logic          w_unused_ld;

    store_align u_align (
        .i_addr_lo    (st_addr_i[2:0]),
        .i_data       (st_data_i),
        .i_size       (st_byte_en_i),
        .o_data       (w_al_data),
        .o_strb       (w_al_strb),
        .o_misaligned (w_al_mis)
    );

    assign st_ready_o      = (r_count < CW'(DEPTH));
    assign w_accept        = st_valid_i && st_ready_o;
    assign w_push          = w_accept && !w_al_mis;
    assign w_pop           = (r_state == SB_BUSY) && mem_gnt_i;
    assign st_misaligned_o = r_mis;
    assign mem_req_o       = (r_state == SB_BUSY);
    assign mem_addr_o      = r_mem_addr;
    assign mem_wr_data_o   = r_mem_data;
    assign mem_wr_strb_o   = r_mem_strb;
    assign count_o         = r_count;
    assign empty_o         = (r_count == '0);
    assign ld_hazard_o     = w_hazard;
    assign w_unused_ld     = ^ld_addr_i[2:0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= SB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // On a grant with more work queued, the following entry is loaded on the same edge.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_idx   = r_head;
        case (r_state)
            SB_IDLE: begin
                if (r_count != '0) begin
                    w_next_state = SB_BUSY;
                    w_load       = 1'b1;
                end
            end
            SB_BUSY: begin
                if (mem_gnt_i) begin
                    if (r_count > CW'(1)) begin
                        w_load     = 1'b1;
                        w_load_idx = r_head + PW'(1);
                    end else begin
                        w_next_state = SB_IDLE;
                    end
                end
            end
            default: w_next_state = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_mis      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_strb <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_mis <= w_accept && w_al_mis;
            if (w_push) begin
                r_mem[r_tail] <= '{row_addr: st_addr_i[63:3], data: w_al_data, strb: w_al_strb};
                r_tail        <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                r_mem_addr <= {r_mem[w_load_idx].row_addr, 3'b000};
                r_mem_data <= r_mem[w_load_idx].data;
                r_mem_strb <= r_mem[w_load_idx].strb;
            end
        end
    end

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        w_hazard = 1'b0;
        w_off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_head;
            if (({1'b0, w_off} < r_count) && (r_mem[i].row_addr == ld_addr_i[63:3])) begin
                w_hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed test-plan steps plus a random
// phase, checked against a queue-based transaction model.
module tb_store_buffer;
    import cpu_consts::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] row;
        logic [63:0] data;
        logic [7:0]  strb;
    } ent_t;

    logic                   clk_i = 1'b0;
    logic                   reset_i = 1'b1;
    logic                   st_valid_i = 1'b0;
    logic                   st_ready_o;
    logic [63:0]            st_addr_i = '0;
    logic [63:0]            st_data_i = '0;
    logic [1:0]             st_byte_en_i = BYTE;
    logic                   st_misaligned_o;
    logic                   mem_req_o;
    logic                   mem_gnt_i = 1'b0;
    logic [63:0]            mem_addr_o;
    logic [63:0]            mem_wr_data_o;
    logic [7:0]             mem_wr_strb_o;
    logic [63:0]            ld_addr_i = '0;
    logic                   ld_hazard_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   empty_o;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t q[$];

    always #5 clk_i = ~clk_i;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .st_valid_i      (st_valid_i),
        .st_ready_o      (st_ready_o),
        .st_addr_i       (st_addr_i),
        .st_data_i       (st_data_i),
        .st_byte_en_i    (st_byte_en_i),
        .st_misaligned_o (st_misaligned_o),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_addr_o      (mem_addr_o),
        .mem_wr_data_o   (mem_wr_data_o),
        .mem_wr_strb_o   (mem_wr_strb_o),
        .ld_addr_i       (ld_addr_i),
        .ld_hazard_o     (ld_hazard_o),
        .count_o         (count_o),
        .empty_o         (empty_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference alignment: copy each store byte into its lane of the row.
    function automatic void modelStore(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                                       output bit mis, output ent_t e);
        int idx;
        int nbytes;
        idx    = int'(a[2:0]);
        nbytes = 1 << sz;
        mis    = (idx % nbytes) != 0;
        e.row  = {a[63:3], 3'b000};
        e.data = '0;
        e.strb = '0;
        if (!mis) begin
            for (int b = 0; b < nbytes; b++) begin
                e.strb[idx + b]          = 1'b1;
                e.data[8*(idx + b) +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    function automatic bit modelHazard(input logic [63:0] la);
        bit hz = 1'b0;
        foreach (q[i]) begin
            if (q[i].row[63:3] == la[63:3]) hz = 1'b1;
        end
        return hz;
    endfunction

    // One clock: drive inputs, check pre-edge state against the model, advance.
    task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] d,
                                 input logic [1:0] sz, input logic g, input logic [63:0] la);
        bit   acc;
        bit   mis;
        bit   exp_mis;
        ent_t e;
        int   pre_size;
        st_valid_i   = v;
        st_addr_i    = a;
        st_data_i    = d;
        st_byte_en_i = sz;
        mem_gnt_i    = g;
        ld_addr_i    = la;
        #1;
        pre_size = q.size();
        checkOutput("count", 64'(count_o), 64'(pre_size));
        checkOutput("ready", 64'(st_ready_o), 64'(pre_size < DEPTH));
        checkOutput("empty", 64'(empty_o), 64'(pre_size == 0));
        checkOutput("hazard", 64'(ld_hazard_o), 64'(modelHazard(la)));
        if (pre_size == 0) checkOutput("req_idle", 64'(mem_req_o), 64'(0));
        if (g && mem_req_o && pre_size > 0) begin
            checkOutput("wr_addr", mem_addr_o, q[0].row);
            checkOutput("wr_data", mem_wr_data_o, q[0].data);
            checkOutput("wr_strb", 64'(mem_wr_strb_o), 64'(q[0].strb));
            void'(q.pop_front());
        end
        acc = v && (pre_size < DEPTH);
        modelStore(a, d, sz, mis, e);
        exp_mis = acc && mis;
        if (acc && !mis) q.push_back(e);
        @(posedge clk_i);
        #1;
        checkOutput("misaligned", 64'(st_misaligned_o), 64'(exp_mis));
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rl;
        int          budget;

        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_ready", 64'(st_ready_o), 64'(1));
        checkOutput("rst_empty", 64'(empty_o), 64'(1));
        checkOutput("rst_count", 64'(count_o), 64'(0));
        checkOutput("rst_mis", 64'(st_misaligned_o), 64'(0));
        checkOutput("rst_req", 64'(mem_req_o), 64'(0));
        checkOutput("rst_addr", mem_addr_o, 64'(0));
        checkOutput("rst_data", mem_wr_data_o, 64'(0));
        checkOutput("rst_strb", 64'(mem_wr_strb_o), 64'(0));
        checkOutput("rst_hazard", 64'(ld_hazard_o), 64'(0));
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Byte store and its latency, then load hazard before/after grant
        applyStimulus(1, 64'h1003, 64'hAB, BYTE, 0, 64'h0);
        checkOutput("byte_count_n1", 64'(count_o), 64'(1));
        checkOutput("byte_req_n1", 64'(mem_req_o), 64'(0));
        applyStimulus(0, 64'h0, 64'h0, BYTE, 0, 64'h1007);
        checkOutput("byte_req_n2", 64'(mem_req_o), 64'(1));
        checkOutput("byte_addr", mem_addr_o, 64'h1000);
        checkOutput("byte_data", mem_wr_data_o, 64'h0000_0000_AB00_0000);
        checkOutput("byte_strb", 64'(mem_wr_strb_o), 64'h08);
        applyStimulus(0, 64'h0, 64'h0, BYTE, 0, 64'h1008);
        applyStimulus(0, 64'h0, 64'h0, BYTE, 1, 64'h1007);
        applyStimulus(0, 64'h0, 64'h0, BYTE, 0, 64'h1007);
        checkOutput("byte_req_done", 64'(mem_req_o), 64'(0));

        // WORD then DOUBLE_WORD, drained back-to-back
        applyStimulus(1, 64'h2004, 64'h1234_5678, WORD, 0, 64'h0);
        applyStimulus(1, 64'h2000, 64'hFBD2_67A6_10FF_4483, DOUBLE_WORD, 0, 64'h0);
        checkOutput("word_req", 64'(mem_req_o), 64'(1));
        checkOutput("word_data", mem_wr_data_o, 64'h1234_5678_0000_0000);
        checkOutput("word_strb", 64'(mem_wr_strb_o), 64'hF0);
        applyStimulus(0, 64'h0, 64'h0, BYTE, 1, 64'h2000);
        checkOutput("dw_req", 64'(mem_req_o), 64'(1));
        checkOutput("dw_data", mem_wr_data_o, 64'hFBD2_67A6_10FF_4483);
        checkOutput("dw_strb", 64'(mem_wr_strb_o), 64'hFF);
        applyStimulus(0, 64'h0, 64'h0, BYTE, 1, 64'h2000);

        // Misaligned half-word is accepted but dropped
        applyStimulus(1, 64'h3001, 64'hBEEF, HALF_WORD, 0, 64'h3000);
        checkOutput("mis_count", 64'(count_o), 64'(0));
        applyStimulus(0, 64'h0, 64'h0, BYTE, 0, 64'h3000);
        checkOutput("mis_req", 64'(mem_req_o), 64'(0));

        // Fill to DEPTH with no grants, then one grant frees a slot
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 64'h5000 + 64'(i * 8), {$urandom, $urandom}, DOUBLE_WORD, 0, 64'h5000);
        end
        checkOutput("full_ready", 64'(st_ready_o), 64'(0));
        checkOutput("full_count", 64'(count_o), 64'(4));
        applyStimulus(1, 64'h5020, 64'h5555, DOUBLE_WORD, 1, 64'h5020);
        checkOutput("after_gnt_ready", 64'(st_ready_o), 64'(1));
        applyStimulus(1, 64'h5020, 64'h5555, DOUBLE_WORD, 0, 64'h5020);
        checkOutput("fifth_count", 64'(count_o), 64'(4));
        for (int i = 0; i < 4; i++) begin
            checkOutput("b2b_req", 64'(mem_req_o), 64'(1));
            applyStimulus(0, 64'h0, 64'h0, BYTE, 1, 64'h5020);
        end
        checkOutput("b2b_empty", 64'(empty_o), 64'(1));

        // Random traffic over a few rows
        for (int i = 0; i < 300; i++) begin
            ra = 64'h4000 + 64'($urandom_range(0, 3) * 8) + 64'($urandom_range(0, 7));
            rl = 64'h4000 + 64'($urandom_range(0, 4) * 8) + 64'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), ra, {$urandom, $urandom},
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rl);
        end
        budget = 40;
        while (q.size() > 0 && budget > 0) begin
            applyStimulus(0, 64'h0, 64'h0, BYTE, 1, 64'h4000);
            budget--;
        end
        checkOutput("random_drained", 64'(q.size()), 64'(0));

        // Asynchronous reset while busy with three entries
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 64'h6000 + 64'(i * 8), 64'(i + 1), DOUBLE_WORD, 0, 64'h6000);
        end
        applyStimulus(0, 64'h0, 64'h0, BYTE, 0, 64'h6000);
        checkOutput("pre_rst_req", 64'(mem_req_o), 64'(1));
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("arst_req", 64'(mem_req_o), 64'(0));
        checkOutput("arst_count", 64'(count_o), 64'(0));
        checkOutput("arst_hazard", 64'(ld_hazard_o), 64'(0));
        checkOutput("arst_empty", 64'(empty_o), 64'(1));
        q.delete();
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        applyStimulus(1, 64'h7002, 64'hC0DE, HALF_WORD, 0, 64'h7000);
        applyStimulus(0, 64'h0, 64'h0, BYTE, 0, 64'h7000);
        checkOutput("post_rst_req", 64'(mem_req_o), 64'(1));
        checkOutput("post_rst_data", mem_wr_data_o, 64'h0000_0000_C0DE_0000);
        checkOutput("post_rst_strb", 64'(mem_wr_strb_o), 64'h0C);
        applyStimulus(0, 64'h0, 64'h0, BYTE, 1, 64'h7000);
        applyStimulus(0, 64'h0, 64'h0, BYTE, 0, 64'h7000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
